// File: rtl/xaui_reset_ctrl.sv
// XAUI bring-up sequencer: pulses the core reset, waits for lane sync/alignment,
// qualifies link stability and retries a bounded number of times before giving up.
module xaui_reset_ctrl #(
  parameter int unsigned RESET_CYCLES   = 16,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned MAX_RETRIES    = 8
) (
  input  logic       clk156_25,
  input  logic       reset156_25_n,
  input  logic       align_status,
  input  logic [3:0] sync_status,
  input  logic       force_reset,
  output logic       xaui_reset,
  output logic       link_up,
  output logic       link_fail,
  output logic [7:0] retry_cnt
);

  typedef enum logic [4:0] {
    S_RST    = 5'b00001,
    S_WAIT   = 5'b00010,
    S_STABLE = 5'b00100,
    S_UP     = 5'b01000,
    S_FAIL   = 5'b10000
  } state_t;

  // Each state lasts N cycles, i.e. counter values 0..N-1, so exits compare against N-1.
  localparam logic [15:0] RST_LAST    = 16'(RESET_CYCLES - 1);
  localparam logic [15:0] STABLE_LAST = 16'(STABLE_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  RETRY_LIMIT = 8'(MAX_RETRIES);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t      state_r;
  state_t      state_nxt_s;
  logic [15:0] cnt_r;
  logic [15:0] cnt_nxt_s;
  logic [7:0]  retry_r;
  logic [7:0]  retry_nxt_s;
  logic [7:0]  retry_inc_s;
  logic        status_good_s;
  logic        fail_evt_s;
  logic        xaui_reset_r;
  logic        link_up_r;
  logic        link_fail_r;

  // Next-state, failure accounting and counter control.
  always_comb begin
    status_good_s = align_status & (&sync_status);
    state_nxt_s   = state_r;
    retry_nxt_s   = retry_r;
    fail_evt_s    = 1'b0;
    retry_inc_s   = sat_inc8(retry_r);
    cnt_nxt_s     = cnt_r;

    case (state_r)
      S_RST: begin
        if (cnt_r == RST_LAST) state_nxt_s = S_WAIT;
        else                   state_nxt_s = S_RST;
      end
      S_WAIT: begin
        if (status_good_s)              state_nxt_s = S_STABLE;
        else if (cnt_r == TIMEOUT_LAST) fail_evt_s  = 1'b1;
        else                            state_nxt_s = S_WAIT;
      end
      S_STABLE: begin
        if (!status_good_s) begin
          state_nxt_s = S_WAIT;
        end else if (cnt_r == STABLE_LAST) begin
          state_nxt_s = S_UP;
          retry_nxt_s = 8'd0;
        end else begin
          state_nxt_s = S_STABLE;
        end
      end
      S_UP: begin
        if (!status_good_s) fail_evt_s  = 1'b1;
        else                state_nxt_s = S_UP;
      end
      S_FAIL:  state_nxt_s = S_FAIL;
      default: state_nxt_s = S_RST;
    endcase

    if (fail_evt_s) begin
      retry_nxt_s = retry_inc_s;
      state_nxt_s = (retry_inc_s == RETRY_LIMIT) ? S_FAIL : S_RST;
    end else begin
      retry_nxt_s = retry_nxt_s;
    end

    // Software restart overrides everything, including a same-cycle failure.
    if (force_reset) begin
      state_nxt_s = S_RST;
      retry_nxt_s = 8'd0;
    end else begin
      state_nxt_s = state_nxt_s;
    end

    if (force_reset || (state_nxt_s != state_r)) cnt_nxt_s = 16'd0;
    else                                          cnt_nxt_s = sat_inc16(cnt_r);
  end

  // State, counter and registered outputs decoded from the next state.
  always_ff @(posedge clk156_25 or negedge reset156_25_n) begin
    if (!reset156_25_n) begin
      state_r      <= S_RST;
      cnt_r        <= 16'd0;
      retry_r      <= 8'd0;
      xaui_reset_r <= 1'b1;
      link_up_r    <= 1'b0;
      link_fail_r  <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      retry_r      <= retry_nxt_s;
      xaui_reset_r <= (state_nxt_s == S_RST);
      link_up_r    <= (state_nxt_s == S_UP);
      link_fail_r  <= (state_nxt_s == S_FAIL);
    end
  end

  assign xaui_reset = xaui_reset_r;
  assign link_up    = link_up_r;
  assign link_fail  = link_fail_r;
  assign retry_cnt  = retry_r;

endmodule

// File: tb/tb_xaui_reset_ctrl.sv
// Scoreboard bench for xaui_reset_ctrl: every output change is matched, in order,
// against a hand-computed (cycle, value) expectation queued by the stimulus.
module tb_xaui_reset_ctrl;

  logic       clk156_25 = 1'b0;
  logic       reset156_25_n;
  logic       align_status;
  logic [3:0] sync_status;
  logic       force_reset;
  logic       xaui_reset;
  logic       link_up;
  logic       link_fail;
  logic [7:0] retry_cnt;

  xaui_reset_ctrl #(
    .RESET_CYCLES  (4),
    .STABLE_CYCLES (8),
    .TIMEOUT_CYCLES(32),
    .MAX_RETRIES   (2)
  ) dut (
    .clk156_25    (clk156_25),
    .reset156_25_n(reset156_25_n),
    .align_status (align_status),
    .sync_status  (sync_status),
    .force_reset  (force_reset),
    .xaui_reset   (xaui_reset),
    .link_up      (link_up),
    .link_fail    (link_fail),
    .retry_cnt    (retry_cnt)
  );

  always #5 clk156_25 = ~clk156_25;

  typedef struct {
    int          cyc;
    logic [10:0] val;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur_e;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic        end_req = 1'b0;
  logic        end_done = 1'b0;
  logic [10:0] prev_out = 11'bx;
  logic [10:0] out_s;

  assign out_s = {xaui_reset, link_up, link_fail, retry_cnt};

  // Counts rising edges; an output change seen at a falling edge is stamped with this.
  always @(posedge clk156_25) cyc <= cyc + 1;

  function automatic void push(input int c, input logic x, input logic u, input logic f,
                               input logic [7:0] r, input string n);
    exp_t e;
    e.cyc  = c;
    e.val  = {x, u, f, r};
    e.name = n;
    exp_q.push_back(e);
  endfunction

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk156_25);
      #1;
    end
  endtask

  // Monitor: sample on the falling edge, compare each output change against the queue head.
  initial begin
    forever begin
      @(negedge clk156_25);
      if (out_s !== prev_out) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change cyc=%0d got=%h expected no change", cyc, out_s);
        end else begin
          cur_e = exp_q.pop_front();
          if ((cur_e.cyc != cyc) || (cur_e.val !== out_s)) begin
            errors++;
            $display("FAIL %s got cyc=%0d val=%h expected cyc=%0d val=%h",
                     cur_e.name, cyc, out_s, cur_e.cyc, cur_e.val);
          end
        end
        prev_out = out_s;
      end
      if (end_req && !end_done) begin
        checks++;
        if (exp_q.size() != 0) begin
          errors++;
          $display("FAIL drain pending=%0d expected 0 (next %s)", exp_q.size(), exp_q[0].name);
        end
        end_done = 1'b1;
      end
    end
  end

  // Stimulus: vector {xaui_reset, link_up, link_fail, retry_cnt} at the edge count it appears.
  initial begin
    reset156_25_n = 1'b0;
    align_status  = 1'b1;
    sync_status   = 4'hF;
    force_reset   = 1'b0;
    push(1, 1'b1, 1'b0, 1'b0, 8'd0, "reset_state");

    // Case 1: release with good status; 4 edges of reset, up 9 edges after wait entry.
    wait_cyc(3);
    push(7,  1'b0, 1'b0, 1'b0, 8'd0, "c1_reset_release");
    push(16, 1'b0, 1'b1, 1'b0, 8'd0, "c1_link_up");
    reset156_25_n = 1'b1;

    // Case 4: lose lane 2 while up -> one failure, 4-cycle reset, relink clears retry_cnt.
    wait_cyc(20);
    push(21, 1'b1, 1'b0, 1'b0, 8'd1, "c4_lane2_drop");
    push(25, 1'b0, 1'b0, 1'b0, 8'd1, "c4_reset_end");
    push(34, 1'b0, 1'b1, 1'b0, 8'd0, "c4_relink");
    sync_status = 4'b1011;
    wait_cyc(22);
    sync_status = 4'hF;

    // Case 2: restart, then a 1-cycle glitch in the 5th stable cycle just delays link-up.
    wait_cyc(40);
    push(41, 1'b1, 1'b0, 1'b0, 8'd0, "c2_force_reset");
    push(45, 1'b0, 1'b0, 1'b0, 8'd0, "c2_reset_end");
    push(60, 1'b0, 1'b1, 1'b0, 8'd0, "c2_link_up_after_glitch");
    force_reset = 1'b1;
    wait_cyc(41);
    force_reset = 1'b0;
    wait_cyc(50);
    align_status = 1'b0;
    wait_cyc(51);
    align_status = 1'b1;

    // Case 3: force coincides with an up-state failure (force wins), then status stays bad.
    wait_cyc(70);
    push(71,  1'b1, 1'b0, 1'b0, 8'd0, "c3_force_beats_failure");
    push(75,  1'b0, 1'b0, 1'b0, 8'd0, "c3_pulse1_end");
    push(107, 1'b1, 1'b0, 1'b0, 8'd1, "c3_timeout1");
    push(111, 1'b0, 1'b0, 1'b0, 8'd1, "c3_pulse2_end");
    push(143, 1'b0, 1'b0, 1'b1, 8'd2, "c3_link_fail");
    align_status = 1'b0;
    force_reset  = 1'b1;
    wait_cyc(71);
    force_reset  = 1'b0;

    // Case 5: status recovers in the fail state (ignored), then force restarts cleanly.
    wait_cyc(150);
    align_status = 1'b1;
    wait_cyc(160);
    push(161, 1'b1, 1'b0, 1'b0, 8'd0, "c5_force_from_fail");
    push(165, 1'b0, 1'b0, 1'b0, 8'd0, "c5_reset_end");
    push(174, 1'b0, 1'b1, 1'b0, 8'd0, "c5_link_up");
    force_reset = 1'b1;
    wait_cyc(161);
    force_reset = 1'b0;

    // Case 6: asynchronous reset mid-cycle while up; visible before the next edge.
    wait_cyc(180);
    #2;
    push(180, 1'b1, 1'b0, 1'b0, 8'd0, "c6_async_reset");
    push(187, 1'b0, 1'b0, 1'b0, 8'd0, "c6_reset_end");
    push(196, 1'b0, 1'b1, 1'b0, 8'd0, "c6_link_up");
    reset156_25_n = 1'b0;
    wait_cyc(183);
    reset156_25_n = 1'b1;

    wait_cyc(215);
    end_req = 1'b1;
    wait (end_done);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
